// File: rtl/arbitro_rr_vc.sv
// Round-robin arbiter moving first-word-fall-through source FIFO heads into the
// destination FIFO named by each word's top two bits, skipping almost-full targets.
module arbitro_rr_vc #(
  parameter int DATA_W = 6,
  parameter int N      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active_in,
  input  logic                error_in,
  input  logic [N-1:0]        fifo_empty_i,
  input  logic [N*DATA_W-1:0] fifo_data_i,
  input  logic [N-1:0]        dest_almost_full_i,
  output logic [N-1:0]        pop_o,
  output logic [N-1:0]        push_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [1:0]          grant_o,
  output logic                idle_o
);

  // state | meaning
  // OFF   | arbitration disabled (inactive, FIFO error, or just out of reset)
  // ARB   | one eligible source popped per cycle, round-robin from rr_ptr
  typedef enum logic {OFF = 1'b0, ARB = 1'b1} state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] head [N];
  logic [N-1:0]      eligible;
  logic [1:0]        idx;
  logic [1:0]        sel;
  logic              found;
  logic              grant_ok;
  logic [DATA_W-1:0] head_sel;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      head[i]     = fifo_data_i[i*DATA_W +: DATA_W];
      eligible[i] = ~fifo_empty_i[i] & ~dest_almost_full_i[head[i][DATA_W-1 -: 2]];
    end
  end

  // Search starts at rr_ptr; the 2-bit add wraps modulo N.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign grant_ok = (state_q == ARB) && found;
  assign head_sel = head[sel];
  assign pop_o    = grant_ok ? (ONE << sel) : '0;
  assign state_d  = (active_in && !error_in) ? ARB : OFF;
  assign rr_ptr_d = grant_ok ? (sel + 2'd1) : rr_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OFF;
      rr_ptr_q <= '0;
      push_o   <= '0;
      data_o   <= '0;
      grant_o  <= '0;
      idle_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idle_o   <= (state_q == ARB) && (&fifo_empty_i) && (pop_o == '0);
      if (grant_ok) begin
        push_o  <= ONE << head_sel[DATA_W-1 -: 2];
        data_o  <= head_sel;
        grant_o <= sel;
      end else begin
        push_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_rr_vc.sv
// Scoreboard bench for arbitro_rr_vc: a cycle model predicts pop_o and queues the
// registered push/data/grant/idle expected one cycle later.
module tb_arbitro_rr_vc;
  localparam int DW = 6;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          active_in = 1'b0;
  logic          error_in = 1'b0;
  logic [N-1:0]  fifo_empty_i = '1;
  logic [N-1:0]  dest_almost_full_i = '0;
  logic [N*DW-1:0] fifo_data_i = '0;
  logic [N-1:0]  pop_o, push_o;
  logic [DW-1:0] data_o;
  logic [1:0]    grant_o;
  logic          idle_o;

  typedef struct packed {
    logic [3:0] push;
    logic [5:0] data;
    logic [1:0] grant;
    logic       idle;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic       m_en = 1'b0;
  logic [1:0] m_rr = '0;
  logic [1:0] m_grant = '0;
  logic [5:0] m_data = '0;

  always #5 clk = ~clk;

  arbitro_rr_vc #(.DATA_W(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .active_in(active_in), .error_in(error_in),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .dest_almost_full_i(dest_almost_full_i), .pop_o(pop_o), .push_o(push_o),
    .data_o(data_o), .grant_o(grant_o), .idle_o(idle_o)
  );

  function automatic logic [N*DW-1:0] heads4(logic [5:0] h0, logic [5:0] h1,
                                             logic [5:0] h2, logic [5:0] h3);
    return {h3, h2, h1, h0};
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_rr = '0; m_grant = '0; m_data = '0;
    sb.delete();
  endtask

  // Reference for one cycle using the inputs currently applied.
  task automatic model_step(output logic [3:0] pe, output exp_t e);
    int s;
    logic [5:0] h;
    s = -1;
    pe = '0;
    e.push = '0; e.data = m_data; e.grant = m_grant; e.idle = 1'b0;
    if (m_en) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (int'(m_rr) + k) % N;
        h = fifo_data_i[i*DW +: DW];
        if (s < 0 && !fifo_empty_i[i] && !dest_almost_full_i[h[5:4]]) s = i;
      end
      if (s >= 0) begin
        h = fifo_data_i[s*DW +: DW];
        pe = 4'b0001 << s;
        e.push = 4'b0001 << h[5:4];
        e.data = h;
        e.grant = 2'(s);
        m_rr = 2'((s + 1) % N);
      end
      e.idle = (&fifo_empty_i) && (pe == 4'b0000);
    end
    m_data = e.data;
    m_grant = e.grant;
    m_en = active_in & ~error_in;
  endtask

  task automatic test_reset();
    logic [3:0] pe;
    exp_t e;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      active_in = 1'($urandom); error_in = 1'($urandom);
      fifo_empty_i = 4'($urandom); dest_almost_full_i = 4'($urandom);
      fifo_data_i = 24'($urandom);
      #2; n_total++;
      if ({pop_o, push_o, data_o, grant_o, idle_o} !== 17'd0)
        $display("FAIL reset_outputs c%0d: got pop=%b push=%b data=%h grant=%0d idle=%b want all 0",
                 c, pop_o, push_o, data_o, grant_o, idle_o);
      else n_pass++;
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; active_in = 1'b0; error_in = 1'b0;
    fifo_empty_i = '1; dest_almost_full_i = '0;
    #2; model_step(pe, e); n_total++;
    if (pop_o !== pe) $display("FAIL reset_release_pop: got %b want %b", pop_o, pe);
    else n_pass++;
    sb.push_back(e);
  endtask

  task automatic test_round_robin();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL rr_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      active_in = 1'b1; error_in = 1'b0; fifo_empty_i = 4'b0000; dest_almost_full_i = '0;
      fifo_data_i = heads4(6'h05, 6'h15, 6'h25, 6'h35);
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL rr_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
      if (c >= 1) begin
        n_total++;
        if (pop_o !== (4'b0001 << ((c - 1) % 4)))
          $display("FAIL rr_sequence c%0d: got %b want %b", c, pop_o, 4'b0001 << ((c - 1) % 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL bp_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      fifo_empty_i = 4'b1001; dest_almost_full_i = 4'b0100;
      fifo_data_i = heads4(6'h00, 6'h2A, 6'h0B, 6'h30);
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL bp_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
      n_total++;
      if (pop_o !== 4'b0100) $display("FAIL bp_vc2_only c%0d: got %b want 0100", c, pop_o);
      else n_pass++;
    end
  endtask

  task automatic test_single_source();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL vc3_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      dest_almost_full_i = '0;
      fifo_data_i = heads4(6'h01, 6'h12, 6'h23, 6'h3C);
      fifo_empty_i = (c < 3) ? 4'b0111 : 4'b0000;
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL vc3_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
    end
  endtask

  task automatic test_error();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL err_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      fifo_empty_i = 4'b0000; dest_almost_full_i = '0;
      fifo_data_i = heads4(6'h07, 6'h17, 6'h27, 6'h37);
      error_in = (c >= 4 && c < 7);
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL err_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
      if (c >= 5 && c <= 7) begin
        n_total++;
        if (pop_o !== 4'b0000) $display("FAIL err_frozen c%0d: got %b want 0000", c, pop_o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_idle_reset();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL idle_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      active_in = 1'b1; error_in = 1'b0; dest_almost_full_i = '0;
      fifo_data_i = heads4(6'h12, 6'h15, 6'h25, 6'h35);
      fifo_empty_i = (c < 3) ? 4'b1111 : 4'b1110;
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL idle_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
      if (c == 2) begin
        n_total++;
        if (idle_o !== 1'b1) $display("FAIL idle_high: got %b want 1", idle_o);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    e = sb.pop_front(); n_total++;
    if ({push_o, data_o, grant_o, idle_o} !== e)
      $display("FAIL pre_reset_push: got %b/%h/%0d/%b want %b/%h/%0d/%b",
               push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
    else n_pass++;
    fifo_empty_i = 4'b0000;
    reset = 1'b0;
    #1; n_total++;
    if ({pop_o, push_o, data_o, grant_o, idle_o} !== 17'd0)
      $display("FAIL async_reset_clear: got pop=%b push=%b data=%h grant=%0d idle=%b want all 0",
               pop_o, push_o, data_o, grant_o, idle_o);
    else n_pass++;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL post_reset_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      reset = 1'b1;
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL post_reset_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
      if (c == 1) begin
        n_total++;
        if (pop_o !== 4'b0001) $display("FAIL first_grant_vc0: got %b want 0001", pop_o);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pe;
    exp_t e;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_total++;
        if ({push_o, data_o, grant_o, idle_o} !== e)
          $display("FAIL rand_out c%0d: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                   c, push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
        else n_pass++;
      end
      active_in = ($urandom_range(0, 9) != 0);
      error_in = ($urandom_range(0, 9) == 0);
      fifo_empty_i = 4'($urandom) & 4'($urandom);
      dest_almost_full_i = 4'($urandom) & 4'($urandom);
      fifo_data_i = 24'($urandom);
      #2; model_step(pe, e); n_total++;
      if (pop_o !== pe) $display("FAIL rand_pop c%0d: got %b want %b", c, pop_o, pe);
      else n_pass++;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front(); n_total++;
      if ({push_o, data_o, grant_o, idle_o} !== e)
        $display("FAIL rand_out_last: got %b/%h/%0d/%b want %b/%h/%0d/%b",
                 push_o, data_o, grant_o, idle_o, e.push, e.data, e.grant, e.idle);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_source();
    test_error();
    test_idle_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
